// File: rtl/muldiv_sequencer.sv
// Multi-cycle RV32M execution controller: one MUL/DIV-class op at a time,
// multiplies through a registered 64-bit product, divides through a restoring divider.
module muldiv_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic        KILL,
  input  logic [4:0]  SELECT,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT,
  output logic [1:0]  dbg_state
);

  // Handshake: START is taken only in IDLE with a valid M-code and KILL low; BUSY
  // covers the op from the edge after acceptance; DONE pulses one cycle with RESULT.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        prep_q, prep_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] prod_q, prod_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_d, done_d;
  logic [31:0] result_d;

  assign dbg_state = state_q;

  // Request decode in IDLE
  logic sel_valid, in_special;
  assign sel_valid  = START && !KILL && (SELECT[1:0] == 2'b01);
  assign in_special = SELECT[4] && ((DATA2 == 32'd0) ||
                      (!SELECT[2] && DATA1 == 32'h8000_0000 && DATA2 == 32'hFFFF_FFFF));

  // op_q holds SELECT[3:2]: for multiplies it picks the half/signedness,
  // for divides bit 1 = remainder, bit 0 = unsigned.
  logic        mul_a_sx, mul_b_sx;
  logic [63:0] mul_full;
  assign mul_a_sx = (op_q != 2'b10) && a_q[31];
  assign mul_b_sx = (op_q == 2'b01) && b_q[31];
  assign mul_full = {{32{mul_a_sx}}, a_q} * {{32{mul_b_sx}}, b_q};

  logic        div_signed, div_is_rem;
  logic [31:0] a_mag, b_mag;
  assign div_signed = !op_q[0];
  assign div_is_rem = op_q[1];
  assign a_mag      = (div_signed && a_q[31]) ? -a_q : a_q;
  assign b_mag      = (div_signed && b_q[31]) ? -b_q : b_q;

  // One restoring step: shift {rem,quo} left, trial-subtract the divisor
  logic [32:0] shifted;
  logic        fits;
  logic [31:0] diff;
  assign shifted = {rem_q, quo_q[31]};
  assign fits    = shifted >= {1'b0, dvsr_q};
  assign diff    = shifted[31:0] - dvsr_q;

  logic        is_special;
  logic [31:0] special_res, quo_fix, rem_fix;
  assign is_special  = (b_q == 32'd0) ||
                       (div_signed && a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF);
  assign special_res = (b_q == 32'd0) ? (div_is_rem ? a_q : 32'hFFFF_FFFF)
                                      : (div_is_rem ? 32'd0 : 32'h8000_0000);
  assign quo_fix     = (div_signed && (a_q[31] ^ b_q[31])) ? -quo_q : quo_q;
  assign rem_fix     = (div_signed && a_q[31]) ? -rem_q : rem_q;

  always_ff @(posedge CLK) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    prep_d   = prep_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    prod_d   = prod_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvsr_d   = dvsr_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    result_d = RESULT;

    unique case (state_q)
      S_IDLE: begin
        if (sel_valid) begin
          op_d   = SELECT[3:2];
          a_d    = DATA1;
          b_d    = DATA2;
          prep_d = 1'b1;
          cnt_d  = 6'd0;
          if (!SELECT[4])     state_d = S_MUL;
          else if (in_special) state_d = S_FIX;
          else                state_d = S_DIV;
        end
      end
      S_MUL: begin
        if (prep_q) begin
          prod_d = mul_full;
          prep_d = 1'b0;
        end else begin
          result_d = (op_q == 2'b00) ? prod_q[31:0] : prod_q[63:32];
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DIV: begin
        if (prep_q) begin
          rem_d  = 32'd0;
          quo_d  = a_mag;
          dvsr_d = b_mag;
          cnt_d  = 6'd0;
          prep_d = 1'b0;
        end else begin
          rem_d = fits ? diff : shifted[31:0];
          quo_d = {quo_q[30:0], fits};
          if (cnt_q == 6'd31) begin
            cnt_d   = 6'd0;
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      S_FIX: begin
        if (prep_q) begin
          prep_d = 1'b0;
        end else begin
          result_d = is_special ? special_res : (div_is_rem ? rem_fix : quo_fix);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush overrides everything: no result, no pulse
    if (KILL) begin
      state_d  = S_IDLE;
      prep_d   = 1'b0;
      cnt_d    = 6'd0;
      done_d   = 1'b0;
      result_d = RESULT;
    end

    busy_d = (state_q != S_IDLE) && (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prep_q <= 1'b0;
      op_q   <= 2'b00;
      a_q    <= 32'd0;
      b_q    <= 32'd0;
      prod_q <= 64'd0;
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvsr_q <= 32'd0;
      cnt_q  <= 6'd0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      RESULT <= 32'd0;
    end else begin
      prep_q <= prep_d;
      op_q   <= op_d;
      a_q    <= a_d;
      b_q    <= b_d;
      prod_q <= prod_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvsr_q <= dvsr_d;
      cnt_q  <= cnt_d;
      BUSY   <= busy_d;
      DONE   <= done_d;
      RESULT <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, hand-written corner
// sequences, and random ops checked against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        START;
  logic        KILL;
  logic [4:0]  SELECT;
  logic [31:0] DATA1;
  logic [31:0] DATA2;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;
  logic [1:0]  dbg_state;

  muldiv_sequencer dut (
    .CLK(CLK), .RESET(RESET), .START(START), .KILL(KILL), .SELECT(SELECT),
    .DATA1(DATA1), .DATA2(DATA2), .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT),
    .dbg_state(dbg_state)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    int          exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic checki(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Reference model: RV32M semantics from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     w;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    w  = 64'd0;
    case (sel)
      5'b00001: begin w = sa * sb;          return w[31:0];  end
      5'b00101: begin w = sa * sb;          return w[63:32]; end
      5'b01001: begin w = ua * ub;          return w[63:32]; end
      5'b01101: begin w = sa * longint'(ub); return w[63:32]; end
      5'b10001: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        w = sa / sb; return w[31:0];
      end
      5'b10101: begin
        if (b == 0) return 32'hFFFF_FFFF;
        w = ua / ub; return w[31:0];
      end
      5'b11001: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        w = sa % sb; return w[31:0];
      end
      5'b11101: begin
        if (b == 0) return a;
        w = ua % ub; return w[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b);
    if (!sel[4]) return 2;
    if (b == 0) return 2;
    if (!sel[2] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one op; inputs are scrambled after acceptance. lat = -1 on timeout.
  task automatic issue(input logic [4:0] sel, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int busy_cnt,
                       output logic busy0, output logic busy_done);
    @(negedge CLK);
    START = 1'b1; SELECT = sel; DATA1 = a; DATA2 = b;
    @(posedge CLK); #1;
    busy0 = BUSY;
    START = 1'b0; SELECT = 5'($urandom); DATA1 = $urandom; DATA2 = $urandom;
    lat = -1; busy_cnt = 0; res = 32'hDEAD_BEEF; busy_done = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK); #1;
      if (DONE) begin
        lat = n; res = RESULT; busy_done = BUSY;
        break;
      end
      if (BUSY) busy_cnt++;
    end
  endtask

  task automatic watch_idle(input int cycles, output int activity);
    activity = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge CLK); #1;
      if (BUSY || DONE) activity++;
    end
  endtask

  logic [31:0] res, prev;
  int          lat, bcnt, act;
  logic        b0, bd;

  initial begin
    vecs[0]  = '{5'b00001, 32'd7,          32'd6,          32'd42,          2};
    vecs[1]  = '{5'b00101, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000,   2};
    vecs[2]  = '{5'b01001, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,   2};
    vecs[3]  = '{5'b01101, 32'hFFFF_FFFF,  32'h0000_0002,  32'hFFFF_FFFF,   2};
    vecs[4]  = '{5'b10001, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,   34};
    vecs[5]  = '{5'b11001, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,   34};
    vecs[6]  = '{5'b10101, 32'd100,        32'd7,          32'd14,          34};
    vecs[7]  = '{5'b11101, 32'd100,        32'd7,          32'd2,           34};
    vecs[8]  = '{5'b10101, 32'd5,          32'd0,          32'hFFFF_FFFF,   2};
    vecs[9]  = '{5'b11001, 32'h8000_0000,  32'd0,          32'h8000_0000,   2};
    vecs[10] = '{5'b10001, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,   2};
    vecs[11] = '{5'b11001, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,           2};
    vecs[12] = '{5'b10101, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,   34};
    vecs[13] = '{5'b10001, 32'h8000_0000,  32'd1,          32'h8000_0000,   34};
    vecs[14] = '{5'b01001, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000,   2};
    vecs[15] = '{5'b11101, 32'd7,          32'd0,          32'd7,           2};

    RESET = 1'b1; START = 1'b0; KILL = 1'b0; SELECT = '0; DATA1 = '0; DATA2 = '0;
    repeat (2) @(posedge CLK);
    #1;
    check32("reset_busy", {31'd0, BUSY}, 32'd0);
    check32("reset_done", {31'd0, DONE}, 32'd0);
    check32("reset_result", RESULT, 32'd0);
    @(negedge CLK) RESET = 1'b0;

    // Directed table, issued back-to-back (each START lands in the previous DONE cycle)
    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].sel, vecs[i].a, vecs[i].b, res, lat, bcnt, b0, bd);
      check32($sformatf("vec%0d_result", i), res, vecs[i].exp_res);
      checki($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      checki($sformatf("vec%0d_busy_cycles", i), bcnt, vecs[i].exp_lat - 1);
      check32($sformatf("vec%0d_busy_edges", i), {30'd0, b0, bd}, 32'd0);
    end
    @(posedge CLK); #1;
    check32("done_one_cycle", {31'd0, DONE}, 32'd0);
    check32("result_held", RESULT, 32'd7);

    // Non-M SELECT is ignored
    @(negedge CLK);
    START = 1'b1; SELECT = 5'b00000; DATA1 = 32'd1; DATA2 = 32'd2;
    @(posedge CLK); #1; START = 1'b0;
    watch_idle(4, act);
    checki("invalid_select_activity", act, 0);
    check32("invalid_select_result", RESULT, 32'd7);

    // KILL together with START wins
    @(negedge CLK);
    START = 1'b1; KILL = 1'b1; SELECT = 5'b00001; DATA1 = 32'd5; DATA2 = 32'd5;
    @(posedge CLK); #1; START = 1'b0; KILL = 1'b0;
    watch_idle(4, act);
    checki("kill_start_activity", act, 0);

    // KILL at cycle 10 of a divide, then a normal multiply
    @(negedge CLK);
    START = 1'b1; SELECT = 5'b10001; DATA1 = 32'd1000; DATA2 = 32'd3;
    @(posedge CLK); #1; START = 1'b0;
    prev = RESULT;
    repeat (9) @(posedge CLK);
    @(negedge CLK) KILL = 1'b1;
    @(posedge CLK); #1; KILL = 1'b0;
    check32("kill_busy", {31'd0, BUSY}, 32'd0);
    check32("kill_done", {31'd0, DONE}, 32'd0);
    check32("kill_result", RESULT, prev);
    watch_idle(40, act);
    checki("kill_no_done", act, 0);
    issue(5'b00001, 32'd3, 32'd3, res, lat, bcnt, b0, bd);
    check32("after_kill_mul", res, 32'd9);
    checki("after_kill_latency", lat, 2);

    // START held while BUSY must not start a second op
    @(negedge CLK);
    START = 1'b1; SELECT = 5'b10101; DATA1 = 32'd100; DATA2 = 32'd7;
    @(posedge CLK); #1;
    SELECT = 5'b00001; DATA1 = 32'd2; DATA2 = 32'd2;
    lat = -1; res = 32'hDEAD_BEEF;
    for (int n = 1; n <= 60; n++) begin
      @(posedge CLK); #1;
      if (n == 33) START = 1'b0;
      if (DONE) begin lat = n; res = RESULT; break; end
    end
    START = 1'b0;
    check32("busy_start_result", res, 32'd14);
    checki("busy_start_latency", lat, 34);
    watch_idle(6, act);
    checki("busy_start_ignored", act, 0);

    // RESET mid-divide
    @(negedge CLK);
    START = 1'b1; SELECT = 5'b10001; DATA1 = 32'd12345; DATA2 = 32'd7;
    @(posedge CLK); #1; START = 1'b0;
    repeat (5) @(posedge CLK);
    @(negedge CLK) RESET = 1'b1;
    @(posedge CLK); #1;
    check32("midreset_busy", {31'd0, BUSY}, 32'd0);
    check32("midreset_done", {31'd0, DONE}, 32'd0);
    check32("midreset_result", RESULT, 32'd0);
    @(negedge CLK) RESET = 1'b0;
    watch_idle(40, act);
    checki("midreset_no_done", act, 0);

    // Random ops against the reference model
    for (int i = 0; i < 60; i++) begin
      logic [4:0]  s;
      logic [31:0] a, b;
      int          el;
      s  = {3'($urandom_range(0, 7)), 2'b01};
      a  = pick_operand();
      b  = pick_operand();
      el = model_lat(s, a, b);
      exp_q.push_back(model(s, a, b));
      issue(s, a, b, res, lat, bcnt, b0, bd);
      check32($sformatf("rand%0d_sel%b_%h_%h", i, s, a, b), res, exp_q.pop_front());
      checki($sformatf("rand%0d_latency", i), lat, el);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
